// File: rtl/icon_pkg.sv
// Shared types, geometry constants, default palette and base sprite images
// for the Rojobot icon generator.
package icon_pkg;

    localparam int unsigned ICON_SIZE  = 16;
    localparam int unsigned ICON_HALF  = 8;
    localparam int unsigned PIX_W      = 12;
    localparam int unsigned CRD_W      = 13;
    localparam int unsigned LOC_W      = 8;
    localparam int unsigned ROM_AW     = 9;
    localparam int unsigned ROM_DEPTH  = 512;
    localparam int unsigned ROW_W      = 2 * ICON_SIZE;

    typedef enum logic [2:0] {
        HDG_N  = 3'd0,
        HDG_NE = 3'd1,
        HDG_E  = 3'd2,
        HDG_SE = 3'd3,
        HDG_S  = 3'd4,
        HDG_SW = 3'd5,
        HDG_W  = 3'd6,
        HDG_NW = 3'd7
    } heading_e;

    typedef logic [1:0]       pal_idx_t;
    typedef logic [PIX_W-1:0] rgb_t;

    // Bot position/heading as captured at the start of a frame.
    typedef struct packed {
        logic [LOC_W-1:0] loc_x;
        logic [LOC_W-1:0] loc_y;
        heading_e         hdg;
    } bot_pos_t;

    localparam rgb_t DEF_COLOR_BODY = 12'h111;
    localparam rgb_t DEF_COLOR_TRIM = 12'hF00;
    localparam rgb_t DEF_COLOR_EYE  = 12'hFF0;

    // One word per sprite row; pixel c lives in bits [2c+1:2c].
    localparam logic [ROW_W-1:0] IMG_N [ICON_SIZE] = '{
        32'hC000_0201, 32'h0001_4000, 32'h0007_D000, 32'h0015_5400,
        32'h0055_5500, 32'h0155_5540, 32'h0555_5550, 32'h0A55_55A0,
        32'h0A55_55A0, 32'h0555_5550, 32'h0155_5540, 32'h0055_5500,
        32'h0028_2800, 32'h0028_2800, 32'h00AA_AA00, 32'hC000_0002
    };

    localparam logic [ROW_W-1:0] IMG_NE [ICON_SIZE] = '{
        32'h5400_0002, 32'h1D00_0000, 32'h0554_0000, 32'h0155_0000,
        32'h0055_4000, 32'h0055_5000, 32'h0155_5400, 32'h0555_5500,
        32'h0A55_5540, 32'h0A55_5550, 32'h0255_5540, 32'h0095_5400,
        32'h0025_5000, 32'h000A_4000, 32'h0002_0000, 32'h0000_0001
    };

    // ROM word for address {base, row, col}.
    function automatic pal_idx_t rom_word(input logic [ROM_AW-1:0] addr);
        logic [ROW_W-1:0] row;
        row = addr[8] ? IMG_NE[addr[7:4]] : IMG_N[addr[7:4]];
        return row[{addr[3:0], 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/icon_sprite_gen_if.sv
// Pixel-stream bus between timing generator / bot registers and the icon
// generator: master drives pixel position and bot state, slave returns icon.
interface icon_sprite_gen_if;
    import icon_pkg::*;

    logic [PIX_W-1:0] pixel_row;
    logic [PIX_W-1:0] pixel_column;
    logic             video_on_in;
    logic [LOC_W-1:0] loc_x;
    logic [LOC_W-1:0] loc_y;
    logic [7:0]       bot_info;
    rgb_t             icon;
    logic             video_on_out;

    modport master (
        output pixel_row, pixel_column, video_on_in, loc_x, loc_y, bot_info,
        input  icon, video_on_out
    );

    modport slave (
        input  pixel_row, pixel_column, video_on_in, loc_x, loc_y, bot_info,
        output icon, video_on_out
    );
endinterface

// File: rtl/icon_rom.sv
// 512 x 2-bit synchronous sprite ROM; contents come from the package images.
module icon_rom
    import icon_pkg::*;
(
    input  logic              clk,
    input  logic [ROM_AW-1:0] addr,
    output pal_idx_t          data
);

    pal_idx_t rom_c [ROM_DEPTH];
    pal_idx_t data_q;

    // Constant table expanded from the two base images.
    always_comb begin
        for (int i = 0; i < int'(ROM_DEPTH); i++) begin
            rom_c[i] = rom_word(ROM_AW'(i));
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        data_q <= rom_c[addr];
    end

    assign data = data_q;

endmodule

// File: rtl/icon_sprite_gen.sv
// Rojobot icon pixel generator: latches bot pose once per frame, renders a
// rotated 16x16 sprite around the bot position, 2-cycle registered output.
// Optional ICON_BLINK_EN: 6-bit frame counter hides the icon 32 of 64 frames.
module icon_sprite_gen
    import icon_pkg::*;
#(
    parameter int unsigned SCALE_SHIFT = 2,
    parameter int          X_OFFSET    = 256,
    parameter int          Y_OFFSET    = 128,
    parameter rgb_t        COLOR_BODY  = DEF_COLOR_BODY,
    parameter rgb_t        COLOR_TRIM  = DEF_COLOR_TRIM,
    parameter rgb_t        COLOR_EYE   = DEF_COLOR_EYE
) (
    input  logic             clk,
    input  logic             reset,
    icon_sprite_gen_if.slave bus
);

    localparam logic [3:0] EDGE = 4'(ICON_SIZE - 1);

    bot_pos_t                pos_q;
    bot_pos_t                pos_d;
    logic                    frame_start_c;

    logic signed [CRD_W-1:0] cx_c;
    logic signed [CRD_W-1:0] cy_c;
    logic signed [CRD_W-1:0] ox_c;
    logic signed [CRD_W-1:0] oy_c;
    logic signed [CRD_W-1:0] ox_end_c;
    logic signed [CRD_W-1:0] oy_end_c;
    logic signed [CRD_W-1:0] row_s_c;
    logic signed [CRD_W-1:0] col_s_c;
    logic                    in_box_c;
    logic [3:0]              r_c;
    logic [3:0]              c_c;
    logic [3:0]              sr_c;
    logic [3:0]              sc_c;
    logic [ROM_AW-1:0]       addr_c;

    logic                    in_box_q;
    logic                    von1_q;
    pal_idx_t                rom_data;

    rgb_t                    icon_d;
    rgb_t                    icon_q;
    logic                    von2_q;
    logic                    vis_c;
    logic                    unused_c;

    assign unused_c = ^bus.bot_info[7:3];

    function automatic rgb_t palette(input pal_idx_t idx);
        case (idx)
            2'd1:    return COLOR_BODY;
            2'd2:    return COLOR_TRIM;
            2'd3:    return COLOR_EYE;
            default: return '0;
        endcase
    endfunction

    // Capture bot pose on the first pixel of each frame, hold otherwise.
    always_comb begin
        pos_d         = pos_q;
        frame_start_c = (bus.pixel_row == '0) && (bus.pixel_column == '0);
        if (frame_start_c) begin
            pos_d.loc_x = bus.loc_x;
            pos_d.loc_y = bus.loc_y;
            pos_d.hdg   = heading_e'(bus.bot_info[2:0]);
        end
    end

    // Stage 1: box test, sprite-local coordinates, rotation and ROM address.
    always_comb begin
        cx_c     = CRD_W'(X_OFFSET) + (CRD_W'(pos_q.loc_x) << SCALE_SHIFT);
        cy_c     = CRD_W'(Y_OFFSET) + (CRD_W'(pos_q.loc_y) << SCALE_SHIFT);
        ox_c     = cx_c - CRD_W'(ICON_HALF);
        oy_c     = cy_c - CRD_W'(ICON_HALF);
        ox_end_c = ox_c + CRD_W'(ICON_SIZE - 1);
        oy_end_c = oy_c + CRD_W'(ICON_SIZE - 1);
        row_s_c  = $signed({1'b0, bus.pixel_row});
        col_s_c  = $signed({1'b0, bus.pixel_column});
        // Signed compares so a box hanging off the top/left edge clips.
        in_box_c = (row_s_c >= oy_c) && (row_s_c <= oy_end_c) &&
                   (col_s_c >= ox_c) && (col_s_c <= ox_end_c);
        r_c      = 4'(row_s_c - oy_c);
        c_c      = 4'(col_s_c - ox_c);
        sr_c     = r_c;
        sc_c     = c_c;
        case (pos_q.hdg[2:1])
            2'd1: begin sr_c = EDGE - c_c; sc_c = r_c;        end
            2'd2: begin sr_c = EDGE - r_c; sc_c = EDGE - c_c; end
            2'd3: begin sr_c = c_c;        sc_c = EDGE - r_c; end
            default: begin sr_c = r_c;     sc_c = c_c;        end
        endcase
        addr_c   = {pos_q.hdg[0], sr_c, sc_c};
    end

    // ROM read occupies the stage-1 clock alongside the box flag.
    icon_rom u_rom (
        .clk  (clk),
        .addr (addr_c),
        .data (rom_data)
    );

`ifdef ICON_BLINK_EN
    localparam int unsigned FCNT_W = 6;
    logic [FCNT_W-1:0] frame_cnt_q;
    logic [FCNT_W-1:0] frame_cnt_d;

    // Frame counter advances with every pose latch and wraps.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_start_c) begin
            frame_cnt_d = frame_cnt_q + FCNT_W'(1);
        end
    end

    // Frame counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign vis_c = ~frame_cnt_q[FCNT_W-1];
`else
    assign vis_c = 1'b1;
`endif

    // Stage 2: palette lookup, gated by box, video_on and blink.
    always_comb begin
        icon_d = '0;
        if (in_box_q && von1_q && vis_c) begin
            icon_d = palette(rom_data);
        end
    end

    // Pose latch and pipeline registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q    <= '0;
            in_box_q <= 1'b0;
            von1_q   <= 1'b0;
            icon_q   <= '0;
            von2_q   <= 1'b0;
        end else begin
            pos_q    <= pos_d;
            in_box_q <= in_box_c;
            von1_q   <= bus.video_on_in;
            icon_q   <= icon_d;
            von2_q   <= von1_q;
        end
    end

    assign bus.icon         = icon_q;
    assign bus.video_on_out = von2_q;

endmodule
